// File: rtl/rs422_frame_pkg.sv
// Shared constants for the main RS422 frame link: header bytes, frame FSM encoding
// and the baud divider helper. The transmitter and the frame receiver both import this.
package rs422_frame_pkg;

    localparam logic [7:0] FRAME_HEAD1 = 8'hAA;
    localparam logic [7:0] FRAME_HEAD2 = 8'h55;
    localparam logic [7:0] FRAME_HEAD3 = 8'hEB;
    localparam logic [7:0] FRAME_HEAD4 = 8'h90;
    localparam logic [7:0] FRAME_HEAD5 = 8'h1D;
    localparam logic [7:0] FRAME_HEAD6 = 8'h1B;
    localparam int unsigned FRAME_HEAD_LEN = 6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_BYTE  = 3'd2;
    localparam logic [2:0] ST_TRAIL = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic int unsigned bit_clks(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic logic [7:0] frame_head(input logic [2:0] i);
        case (i)
            3'd0:    return FRAME_HEAD1;
            3'd1:    return FRAME_HEAD2;
            3'd2:    return FRAME_HEAD3;
            3'd3:    return FRAME_HEAD4;
            3'd4:    return FRAME_HEAD5;
            default: return FRAME_HEAD6;
        endcase
    endfunction

endpackage

// File: rtl/rs422_frame_tx_if.sv
// Host-side request/status bundle of the frame transmitter.
interface rs422_frame_tx_if #(
    parameter int unsigned PAYLOAD_LEN = 8
) ();
    logic                     tx_start;
    logic [PAYLOAD_LEN*8-1:0] payload;
    logic                     tx_busy;
    logic                     tx_done;

    modport master (output tx_start, output payload, input tx_busy, input tx_done);
    modport slave  (input tx_start, input payload, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. done is high in the last cycle of the stop bit so a load in that
// same cycle starts the next start bit with no idle gap.
module uart_byte_tx #(
    parameter int unsigned BIT_CLKS = 434
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output logic       done
);
    localparam int unsigned CW = ($clog2(BIT_CLKS) > 0) ? $clog2(BIT_CLKS) : 1;

    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == CW'(BIT_CLKS - 1));
    assign done    = busy && bit_end && (bit_cnt == 4'd9);

    always_ff @(posedge clkin) begin
        if (rst) begin
            txd      <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            txd      <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (busy) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    busy    <= 1'b0;
                    txd     <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    txd     <= shreg[0];
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    // Stop bit rides in shreg[8]; ones shift in behind it.
    always_ff @(posedge clkin) begin
        if (load)
            shreg <= {1'b1, data};
        else if (busy && bit_end && bit_cnt != 4'd9)
            shreg <= {1'b1, shreg[8:1]};
    end

endmodule

// File: rtl/rs422_frame_tx.sv
// Framed RS422 transmitter: header, latched payload and 16-bit additive checksum sent as
// back-to-back 8N1 bytes, with the driver enable wrapped around the frame by guard times.
module rs422_frame_tx
    import rs422_frame_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned PAYLOAD_LEN = 8,
    parameter int unsigned DE_GUARD    = 16
) (
    input  logic             clkin,
    input  logic             rst,
    rs422_frame_tx_if.slave  host,
    output logic             rs422_di_main,
    output logic             rs422_de_main,
    output logic             rs422_re_n_main
);
    localparam int unsigned FRAME_BYTES = PAYLOAD_LEN + 8;
    localparam int unsigned DATA_END    = FRAME_HEAD_LEN + PAYLOAD_LEN;
    localparam int unsigned GW          = $clog2(DE_GUARD + 1);

    logic [2:0]               state;
    logic [GW-1:0]            gcnt;
    logic [5:0]               idx;
    logic [15:0]              chk;
    logic [PAYLOAD_LEN*8-1:0] shadow;
    logic [7:0]               cur_byte;
    logic                     load;
    logic                     guard_end;
    logic                     u_busy;
    logic                     u_done;

    assign guard_end = (gcnt == GW'(DE_GUARD - 1));

    // Payload bytes come from the top of the shadow, which shifts up as each one loads.
    always_comb begin
        cur_byte = chk[7:0];
        if (idx < 6'(FRAME_HEAD_LEN))
            cur_byte = frame_head(idx[2:0]);
        else if (idx < 6'(DATA_END))
            cur_byte = shadow[PAYLOAD_LEN*8-1 -: 8];
        else if (idx == 6'(DATA_END))
            cur_byte = chk[15:8];
    end

    assign load = (state == ST_LEAD && guard_end) ||
                  (state == ST_BYTE && u_done && idx != 6'(FRAME_BYTES));

    always_ff @(posedge clkin) begin
        if (rst) begin
            state <= ST_IDLE;
            gcnt  <= '0;
            idx   <= '0;
            chk   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (host.tx_start) begin
                    state <= ST_LEAD;
                    gcnt  <= '0;
                    idx   <= '0;
                    chk   <= '0;
                end
                ST_LEAD: if (guard_end) begin
                    state <= ST_BYTE;
                    gcnt  <= '0;
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
                ST_BYTE:  if (u_done && idx == 6'(FRAME_BYTES)) state <= ST_TRAIL;
                ST_TRAIL: if (guard_end) state <= ST_DONE; else gcnt <= gcnt + 1'b1;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            if (load) begin
                idx <= idx + 6'd1;
                if (idx < 6'(DATA_END))
                    chk <= chk + 16'(cur_byte);
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (state == ST_IDLE && host.tx_start)
            shadow <= host.payload;
        else if (load && idx >= 6'(FRAME_HEAD_LEN) && idx < 6'(DATA_END))
            shadow <= shadow << 8;
    end

    uart_byte_tx #(.BIT_CLKS(bit_clks(CLK_FREQ, BAUD))) u_uart (
        .clkin (clkin),
        .rst   (rst),
        .load  (load),
        .data  (cur_byte),
        .txd   (rs422_di_main),
        .busy  (u_busy),
        .done  (u_done)
    );

    assign host.tx_busy    = (state != ST_IDLE);
    assign host.tx_done    = (state == ST_DONE);
    assign rs422_de_main   = (state == ST_LEAD) || (state == ST_BYTE) || (state == ST_TRAIL) || u_busy;
    assign rs422_re_n_main = 1'b0;

endmodule

// File: tb/tb_rs422_frame_tx.sv
// Directed bench for rs422_frame_tx at a fast baud: a line monitor decodes 8N1 bytes and
// frames are checked against hand-computed bytes, timing and enable behaviour.
module tb_rs422_frame_tx;
    import rs422_frame_pkg::*;

    localparam int unsigned CLKF  = 50_000_000;
    localparam int unsigned BAUDR = 10_000_000;
    localparam int unsigned PL    = 8;
    localparam int unsigned G     = 4;
    localparam int B  = 5;
    localparam int NB = PL + 8;
    localparam int L  = 1 + 2*G + NB*10*B + 1;

    logic clkin = 1'b0;
    logic rst   = 1'b1;
    logic di, de, re_n;

    rs422_frame_tx_if #(.PAYLOAD_LEN(PL)) host ();

    rs422_frame_tx #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .PAYLOAD_LEN(PL), .DE_GUARD(G)) dut (
        .clkin           (clkin),
        .rst             (rst),
        .host            (host),
        .rs422_di_main   (di),
        .rs422_de_main   (de),
        .rs422_re_n_main (re_n)
    );

    always #10 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor
    logic [7:0] rx_byte[$];
    int         rx_time[$];
    int         frame_err = 0;
    int         done_cnt  = 0;
    int         de_viol   = 0;
    bit         m_act     = 1'b0;
    int         m_t0, m_off, m_j;
    logic [7:0] m_sh;

    always @(negedge clkin) begin
        if (host.tx_done === 1'b1) done_cnt++;
        if (di === 1'b0 && de !== 1'b1) de_viol++;
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (di === 1'b0) begin
                m_act = 1'b1;
                m_t0  = cyc;
            end
        end else begin
            m_off = cyc - m_t0;
            if (m_off % B == B/2) begin
                m_j = m_off / B;
                if (m_j == 0 && di !== 1'b0) begin
                    frame_err++;
                    m_act = 1'b0;
                end else if (m_j >= 1 && m_j <= 8) begin
                    m_sh[m_j-1] = di;
                end else if (m_j == 9) begin
                    if (di !== 1'b1) frame_err++;
                    rx_byte.push_back(m_sh);
                    rx_time.push_back(m_t0);
                    m_act = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [PL*8-1:0] payload;
        logic [15:0]     chk;
    } vec_t;
    vec_t vecs[4];

    function automatic logic [7:0] exp_byte(input int i, input logic [PL*8-1:0] p, input logic [15:0] ck);
        case (i)
            0: return 8'hAA;
            1: return 8'h55;
            2: return 8'hEB;
            3: return 8'h90;
            4: return 8'h1D;
            5: return 8'h1B;
            default: begin
                if (i < 6 + PL) return p[(PL-1-(i-6))*8 +: 8];
                if (i == 6 + PL) return ck[15:8];
                return ck[7:0];
            end
        endcase
    endfunction

    task automatic start_frame(input logic [PL*8-1:0] p, output int c0);
        @(negedge clkin);
        check("idle_before_start", 32'(host.tx_busy), 32'd0);
        host.payload  = p;
        host.tx_start = 1'b1;
        c0 = cyc;
        @(negedge clkin);
        host.tx_start = 1'b0;
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int k = 0; k < 4*L; k++) begin
            @(negedge clkin);
            if (host.tx_done === 1'b1) begin
                d = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: no tx_done within %0d cycles", 4*L);
    endtask

    task automatic wait_rx(input int n);
        for (int k = 0; k < 4*L && rx_byte.size() < n; k++) @(negedge clkin);
        check("rx_progress", 32'(rx_byte.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input int base, input logic [PL*8-1:0] p, input logic [15:0] ck, input int first);
        int bad;
        check("rx_count", 32'(rx_byte.size() >= base + NB), 32'd1);
        if (rx_byte.size() >= base + NB) begin
            for (int i = 0; i < NB; i++)
                check($sformatf("byte%0d", i), 32'(rx_byte[base+i]), 32'(exp_byte(i, p, ck)));
            check("first_start", 32'(rx_time[base]), 32'(first));
            bad = 0;
            for (int i = 1; i < NB; i++)
                if (rx_time[base+i] - rx_time[base+i-1] != 10*B) bad++;
            check("byte_spacing", 32'(bad), 32'd0);
        end
        check("framing_errors", 32'(frame_err), 32'd0);
        check("de_low_with_data", 32'(de_viol), 32'd0);
    endtask

    task automatic run_frame(input logic [PL*8-1:0] p, input logic [15:0] ck, input bit disturb);
        int c0, d, dc0;
        rx_byte.delete();
        rx_time.delete();
        dc0 = done_cnt;
        start_frame(p, c0);
        check("busy_after_accept", 32'(host.tx_busy), 32'd1);
        check("de_lead", 32'(de), 32'd1);
        if (disturb) begin
            fork
                wait_done(d);
                begin
                    wait_rx(3);
                    repeat (2*B) @(negedge clkin);
                    host.payload  = ~p;
                    host.tx_start = 1'b1;
                    @(negedge clkin);
                    host.tx_start = 1'b0;
                end
            join
        end else begin
            wait_done(d);
        end
        check("latency", 32'(d - c0 + 1), 32'(L));
        check("de_at_done", 32'(de), 32'd0);
        @(negedge clkin);
        check("done_pulse_width", 32'(host.tx_done), 32'd0);
        check_frame(0, p, ck, c0 + G + 1);
        if (disturb) begin
            repeat (4*G + 4*B) @(negedge clkin);
            check("single_done", 32'(done_cnt - dc0), 32'd1);
            check("no_queued_frame", 32'(host.tx_busy), 32'd0);
            check("rx_count_after", 32'(rx_byte.size()), 32'(NB));
        end
    endtask

    initial begin
        int c0, c1, d0, d1, dc0;
        vecs[0] = '{64'h00_01_00_00_10_00_00_00, 16'h02C3};
        vecs[1] = '{64'h00_00_00_00_00_00_00_00, 16'h02B2};
        vecs[2] = '{64'hFF_FF_FF_FF_FF_FF_FF_FF, 16'h0AAA};
        vecs[3] = '{64'h01_02_03_04_05_06_07_08, 16'h02D6};

        host.tx_start = 1'b0;
        host.payload  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clkin);
        check("rst_di", 32'(di), 32'd1);
        check("rst_de", 32'(de), 32'd0);
        check("rst_re_n", 32'(re_n), 32'd0);
        check("rst_busy", 32'(host.tx_busy), 32'd0);
        check("rst_done", 32'(host.tx_done), 32'd0);
        rst = 1'b0;
        @(negedge clkin);
        check("bit_clks_default", bit_clks(50_000_000, 115200), 32'd434);
        check("bit_clks_bench", bit_clks(CLKF, BAUDR), 32'(B));

        for (int i = 0; i < 4; i++)
            run_frame(vecs[i].payload, vecs[i].chk, 1'b0);

        // Second request and payload change while busy
        run_frame(vecs[0].payload, vecs[0].chk, 1'b1);

        // Reset during payload byte 2
        rx_byte.delete();
        rx_time.delete();
        dc0 = done_cnt;
        start_frame(vecs[3].payload, c0);
        wait_rx(8);
        repeat (2*B) @(negedge clkin);
        rst = 1'b1;
        @(negedge clkin);
        check("midrst_di", 32'(di), 32'd1);
        check("midrst_de", 32'(de), 32'd0);
        check("midrst_busy", 32'(host.tx_busy), 32'd0);
        check("midrst_done", 32'(host.tx_done), 32'd0);
        rst = 1'b0;
        repeat (3*G + 10*B) @(negedge clkin);
        check("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
        check("midrst_line_idle", 32'(di), 32'd1);
        run_frame(vecs[3].payload, vecs[3].chk, 1'b0);

        // Back-to-back frames: request in the cycle after tx_done
        rx_byte.delete();
        rx_time.delete();
        start_frame(vecs[0].payload, c0);
        wait_done(d0);
        start_frame(vecs[2].payload, c1);
        check("b2b_accepted", 32'(host.tx_busy), 32'd1);
        wait_done(d1);
        check("b2b_latency", 32'(d1 - c1 + 1), 32'(L));
        check_frame(0, vecs[0].payload, vecs[0].chk, c0 + G + 1);
        check_frame(NB, vecs[2].payload, vecs[2].chk, c1 + G + 1);
        if (rx_byte.size() >= 2*NB)
            check("b2b_line_gap", 32'(rx_time[NB] - (rx_time[NB-1] + 10*B)), 32'(2*G + 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
